// File: rtl/rv32i_types.sv
// Shared types for the L2 eviction-write-buffer drain path.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DONE  = 2'd2
  } drain_state_t;

  localparam int unsigned LINE_OFFSET_BITS = 5;
  localparam int unsigned BEATS_PER_LINE   = 4;

endpackage

// File: rtl/ewb_drain_datapath.sv
// Holds the line being drained and its aligned address; selects the current beat.
module ewb_drain_datapath
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH      = 256,
  parameter int unsigned BEAT_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned BEATS      = WIDTH / BEAT_WIDTH,
  parameter int unsigned BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [WIDTH-1:0]      i_data,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [BEAT_W-1:0]     i_beat,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic [BEAT_WIDTH-1:0] o_beat_data
);

  localparam logic [ADDR_WIDTH-1:0] OFFSET_MASK =
    ADDR_WIDTH'((64'd1 << LINE_OFFSET_BITS) - 64'd1);

  logic [WIDTH-1:0]      r_line;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [BEAT_WIDTH-1:0] w_beats [BEATS];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_line <= '0;
      r_addr <= '0;
    end else if (i_load) begin
      r_line <= i_data;
      r_addr <= i_addr & ~OFFSET_MASK;
    end
  end

  for (genvar g = 0; g < BEATS; g++) begin : g_beat
    assign w_beats[g] = r_line[g*BEAT_WIDTH +: BEAT_WIDTH];
  end

  assign o_addr      = r_addr;
  assign o_beat_data = w_beats[i_beat];

endmodule

// File: rtl/ewb_drain.sv
// Pops the oldest EWB line and writes it to memory as a multi-beat burst,
// yielding to L2 miss fills unless the EWB is full or a flush is pending.
module ewb_drain
  import rv32i_types::*;
#(
  parameter int unsigned WIDTH      = 256,
  parameter int unsigned BEAT_WIDTH = 64,
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ewb_empty_i,
  input  logic                  ewb_full_i,
  input  logic [WIDTH-1:0]      ewb_data_i,
  input  logic [ADDR_WIDTH-1:0] ewb_addr_i,
  output logic                  ewb_yumi_o,
  input  logic                  read_req_i,
  output logic                  busy_o,
  input  logic                  flush_i,
  output logic                  flush_done_o,
  output logic [ADDR_WIDTH-1:0] pmem_address_o,
  output logic                  pmem_write_o,
  output logic [BEAT_WIDTH-1:0] pmem_burst_o,
  input  logic                  pmem_resp_i
);

  localparam int unsigned BEATS  = WIDTH / BEAT_WIDTH;
  localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  drain_state_t          r_state;
  drain_state_t          w_state_next;
  logic [BEAT_W-1:0]     r_beat;
  logic                  r_flush_pending;
  logic                  w_start;
  logic                  w_last_resp;
  logic                  w_flush_done;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [BEAT_WIDTH-1:0] w_beat_data;

  assign w_start      = (r_state == IDLE) && !ewb_empty_i &&
                        (r_flush_pending || ewb_full_i || !read_req_i);
  assign w_last_resp  = (r_state == BURST) && pmem_resp_i &&
                        (r_beat == BEAT_W'(BEATS - 1));
  assign w_flush_done = r_flush_pending && (r_state == IDLE) && ewb_empty_i;

  ewb_drain_datapath #(
    .WIDTH      (WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .BEATS      (BEATS),
    .BEAT_W     (BEAT_W)
  ) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_start),
    .i_data      (ewb_data_i),
    .i_addr      (ewb_addr_i),
    .i_beat      (r_beat),
    .o_addr      (w_addr),
    .o_beat_data (w_beat_data)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // A flush arriving while one is already pending is absorbed by the clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat          <= '0;
      r_flush_pending <= 1'b0;
    end else begin
      if (w_start)                              r_beat <= '0;
      else if (r_state == BURST && pmem_resp_i) r_beat <= r_beat + 1'b1;

      if (w_flush_done) r_flush_pending <= 1'b0;
      else if (flush_i) r_flush_pending <= 1'b1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_next = BURST;
      BURST:   if (w_last_resp) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    ewb_yumi_o     = 1'b0;
    pmem_write_o   = 1'b0;
    pmem_address_o = '0;
    pmem_burst_o   = '0;
    busy_o         = (r_state != IDLE);
    flush_done_o   = w_flush_done;
    case (r_state)
      BURST: begin
        pmem_write_o   = 1'b1;
        pmem_address_o = w_addr;
        pmem_burst_o   = w_beat_data;
      end
      DONE:    ewb_yumi_o = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ewb_drain.sv
// Randomized and scenario-driven check of ewb_drain against a queue-based EWB model.
module tb_ewb_drain;

  localparam int unsigned W   = 256;
  localparam int unsigned BW  = 64;
  localparam int unsigned AW  = 32;
  localparam int unsigned CAP = 4;
  localparam int unsigned NB  = W / BW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ewb_empty_i = 1'b1;
  logic          ewb_full_i = 1'b0;
  logic [W-1:0]  ewb_data_i = '0;
  logic [AW-1:0] ewb_addr_i = '0;
  logic          ewb_yumi_o;
  logic          read_req_i = 1'b0;
  logic          busy_o;
  logic          flush_i = 1'b0;
  logic          flush_done_o;
  logic [AW-1:0] pmem_address_o;
  logic          pmem_write_o;
  logic [BW-1:0] pmem_burst_o;
  logic          pmem_resp_i = 1'b0;

  ewb_drain #(.WIDTH(W), .BEAT_WIDTH(BW), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .ewb_empty_i    (ewb_empty_i),
    .ewb_full_i     (ewb_full_i),
    .ewb_data_i     (ewb_data_i),
    .ewb_addr_i     (ewb_addr_i),
    .ewb_yumi_o     (ewb_yumi_o),
    .read_req_i     (read_req_i),
    .busy_o         (busy_o),
    .flush_i        (flush_i),
    .flush_done_o   (flush_done_o),
    .pmem_address_o (pmem_address_o),
    .pmem_write_o   (pmem_write_o),
    .pmem_burst_o   (pmem_burst_o),
    .pmem_resp_i    (pmem_resp_i)
  );

  always #5 clk = ~clk;

  // EWB contents, oldest first
  logic [AW-1:0] qa[$];
  logic [W-1:0]  qd[$];

  // Line-level model: which line is in flight, how many beats memory has taken
  bit            m_inflight = 0;
  bit            m_done     = 0;
  bit            m_pend     = 0;
  int            m_sent     = 0;
  logic [W-1:0]  m_line     = '0;
  logic [AW-1:0] m_addr     = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  int yumi_cyc[$];
  int fdone_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] rand_line();
    logic [W-1:0] v;
    for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  task automatic push(input logic [AW-1:0] a, input logic [W-1:0] d);
    if (qa.size() < CAP) begin
      qa.push_back(a);
      qd.push_back(d);
    end
  endtask

  task automatic cycle(input bit rreq, input bit resp, input bit fl, input bit r);
    logic [W-1:0]  sh;
    logic [BW-1:0] exp_burst;
    bit            exp_write;
    bit            exp_fd;
    read_req_i  = rreq;
    pmem_resp_i = resp;
    flush_i     = fl;
    rst         = r;
    ewb_empty_i = (qa.size() == 0);
    ewb_full_i  = (qa.size() == CAP);
    if (qa.size() > 0) begin
      ewb_addr_i = qa[0];
      ewb_data_i = qd[0];
    end else begin
      ewb_addr_i = $urandom;
      ewb_data_i = rand_line();
    end
    #1;
    exp_write = m_inflight && !m_done;
    sh        = m_line >> (m_sent * BW);
    exp_burst = exp_write ? sh[BW-1:0] : '0;
    exp_fd    = m_pend && !m_inflight && (qa.size() == 0);
    chk("pmem_write", 64'(pmem_write_o), 64'(exp_write));
    chk("pmem_address", 64'(pmem_address_o), exp_write ? 64'(m_addr) : 64'd0);
    chk("pmem_burst", pmem_burst_o, exp_burst);
    chk("ewb_yumi", 64'(ewb_yumi_o), 64'(m_done));
    chk("busy", 64'(busy_o), 64'(m_inflight));
    chk("flush_done", 64'(flush_done_o), 64'(exp_fd));
    if (ewb_yumi_o) yumi_cyc.push_back(cyc);
    if (flush_done_o) fdone_cyc.push_back(cyc);
    @(posedge clk);
    if (m_done) begin
      void'(qa.pop_front());
      void'(qd.pop_front());
    end
    if (r) begin
      m_inflight = 0;
      m_done     = 0;
      m_sent     = 0;
      m_pend     = 0;
    end else begin
      if (m_done) begin
        m_inflight = 0;
        m_done     = 0;
      end else if (m_inflight) begin
        if (resp) begin
          m_sent++;
          if (m_sent == NB) m_done = 1;
        end
      end else if (qa.size() > 0 && (m_pend || qa.size() == CAP || !rreq)) begin
        m_inflight = 1;
        m_sent     = 0;
        m_line     = qd[0];
        m_addr     = (qa[0] / 32) * 32;
      end
      if (exp_fd) m_pend = 0;
      else if (fl) m_pend = 1;
    end
    cyc++;
    @(negedge clk);
  endtask

  initial begin
    logic [W-1:0] line;
    bit           stall_pat [7] = '{1, 0, 0, 1, 0, 1, 1};
    int           c0;

    repeat (2) @(posedge clk);
    @(negedge clk);

    // Reset state, then single line drain with known beats
    cycle(0, 0, 0, 0);
    line = {64'hA3, 64'hA2, 64'hA1, 64'hA0};
    push(32'h0000_1234, line);
    yumi_cyc.delete();
    c0 = cyc;
    repeat (8) cycle(0, 1, 0, 0);
    chk("single_yumi_count", 64'(yumi_cyc.size()), 64'd1);
    if (yumi_cyc.size() > 0) chk("single_yumi_cycle", 64'(yumi_cyc[0] - c0), 64'd5);

    // Read priority, then full override
    push($urandom, rand_line());
    push($urandom, rand_line());
    repeat (6) cycle(1, 1, 0, 0);
    repeat (14) cycle(0, 1, 0, 0);
    for (int i = 0; i < CAP; i++) push($urandom, rand_line());
    repeat (12) cycle(1, 1, 0, 0);
    repeat (20) cycle(0, 1, 0, 0);

    // Response stalls
    push($urandom, rand_line());
    cycle(0, 0, 0, 0);
    foreach (stall_pat[i]) cycle(0, stall_pat[i], 0, 0);
    repeat (3) cycle(0, 0, 0, 0);

    // Back-to-back drain of three lines
    for (int i = 0; i < 3; i++) push($urandom, rand_line());
    yumi_cyc.delete();
    repeat (20) cycle(0, 1, 0, 0);
    chk("b2b_yumi_count", 64'(yumi_cyc.size()), 64'd3);
    if (yumi_cyc.size() == 3) begin
      chk("b2b_gap0", 64'(yumi_cyc[1] - yumi_cyc[0]), 64'd6);
      chk("b2b_gap1", 64'(yumi_cyc[2] - yumi_cyc[1]), 64'd6);
    end

    // Flush against read priority
    push($urandom, rand_line());
    push($urandom, rand_line());
    yumi_cyc.delete();
    fdone_cyc.delete();
    cycle(1, 1, 1, 0);
    repeat (16) cycle(1, 1, 0, 0);
    chk("flush_yumi_count", 64'(yumi_cyc.size()), 64'd2);
    chk("flush_done_count", 64'(fdone_cyc.size()), 64'd1);
    if (yumi_cyc.size() == 2 && fdone_cyc.size() == 1)
      chk("flush_done_cycle", 64'(fdone_cyc[0] - yumi_cyc[1]), 64'd1);

    // Flush with the EWB empty
    fdone_cyc.delete();
    c0 = cyc;
    cycle(1, 1, 1, 0);
    cycle(1, 1, 0, 0);
    cycle(1, 1, 0, 0);
    chk("empty_flush_count", 64'(fdone_cyc.size()), 64'd1);
    if (fdone_cyc.size() == 1) chk("empty_flush_cycle", 64'(fdone_cyc[0] - c0), 64'd1);

    // Reset after the second beat response
    push($urandom, rand_line());
    yumi_cyc.delete();
    fdone_cyc.delete();
    cycle(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 1);
    cycle(1, 0, 0, 0);
    chk("rst_no_yumi", 64'(yumi_cyc.size()), 64'd0);
    chk("rst_entry_kept", 64'(qa.size()), 64'd1);
    repeat (8) cycle(0, 1, 0, 0);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(99) < 30) push($urandom, rand_line());
      cycle($urandom_range(1), $urandom_range(99) < 70, $urandom_range(99) < 3,
            $urandom_range(999) < 5);
    end
    repeat (40) cycle(0, 1, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
